// File: rtl/audio_recorder.sv
// Capture path: drains the Audio_Controller input FIFO, mixes L/R to mono,
// decimates, and writes words sequentially into the shared single-port RAM.
module audio_recorder #(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned LAST_ADDR = 99,
    parameter int unsigned DECIM     = 1
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    input  logic [31:0]       right_channel_audio_in,
    output logic              read_audio_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sample_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W:0]   SAT     = (ADDR_W+1)'(LAST_ADDR + 1);
    localparam logic [CNT_W-1:0]  KEEP_AT = CNT_W'(DECIM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RECORD = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [CNT_W-1:0]  r_decim_cnt;
    logic [31:0]       r_ram_data;
    logic              r_ram_wren;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   r_sample_count;

    logic signed [31:0] w_left_half;
    logic signed [31:0] w_right_half;
    logic [31:0]        w_mono;
    logic               w_read;
    logic               w_keep;

    // Halving each channel first means the sum can never overflow.
    assign w_left_half  = $signed(left_channel_audio_in) >>> 1;
    assign w_right_half = $signed(right_channel_audio_in) >>> 1;
    assign w_mono       = w_left_half + w_right_half;

    // Pop whenever data is present, except while the write cycle is in flight.
    assign w_read = (r_state != S_WRITE) && audio_in_available;
    assign w_keep = (r_state == S_RECORD) && w_read && (r_decim_cnt == KEEP_AT);

    assign read_audio_in = w_read;
    assign ram_address   = r_wr_addr;
    assign ram_data      = r_ram_data;
    assign ram_wren      = r_ram_wren;
    assign busy          = r_busy;
    assign done          = r_done;
    assign sample_count  = r_sample_count;

    // Recorder FSM with all visible outputs registered alongside the state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_wr_addr      <= '0;
            r_decim_cnt    <= '0;
            r_ram_data     <= '0;
            r_ram_wren     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_sample_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state        <= S_RECORD;
                        r_wr_addr      <= '0;
                        r_decim_cnt    <= '0;
                        r_sample_count <= '0;
                        r_busy         <= 1'b1;
                        r_done         <= 1'b0;
                    end
                end
                S_RECORD: begin
                    if (w_keep) begin
                        r_ram_data  <= w_mono;
                        r_ram_wren  <= 1'b1;
                        r_decim_cnt <= '0;
                        r_state     <= S_WRITE;
                    end else begin
                        if (w_read) begin
                            r_decim_cnt <= r_decim_cnt + CNT_W'(1);
                        end
                        if (stop) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_ram_wren <= 1'b0;
                    if (r_sample_count != SAT) begin
                        r_sample_count <= r_sample_count + (ADDR_W+1)'(1);
                    end
                    // Stop takes priority over wrapping; the address is held on finish.
                    if (stop || ((r_wr_addr == LAST) && !loop_en)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_wr_addr == LAST) begin
                        r_wr_addr <= '0;
                        r_state   <= S_RECORD;
                    end else begin
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        r_state   <= S_RECORD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_recorder.sv
// Directed bench for audio_recorder: one instance with DECIM=1, one with DECIM=4.
module tb_audio_recorder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, start, stop, loop_en, avail;
    logic [31:0] lch, rch;

    logic        rd1, wren1, busy1, done1;
    logic [6:0]  addr1;
    logic [31:0] data1;
    logic [7:0]  sc1;
    logic        rd4, wren4, busy4, done4;
    logic [6:0]  addr4;
    logic [31:0] data4;
    logic [7:0]  sc4;

    int errors = 0;
    int checks = 0;

    logic [6:0]  wa1[$];
    logic [31:0] wd1[$];
    logic [6:0]  wa4[$];
    logic [31:0] wd4[$];

    audio_recorder #(.ADDR_W(7), .LAST_ADDR(99), .DECIM(1)) dut (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .loop_en(loop_en),
        .audio_in_available(avail), .left_channel_audio_in(lch), .right_channel_audio_in(rch),
        .read_audio_in(rd1), .ram_address(addr1), .ram_data(data1), .ram_wren(wren1),
        .busy(busy1), .done(done1), .sample_count(sc1)
    );

    audio_recorder #(.ADDR_W(7), .LAST_ADDR(99), .DECIM(4)) dut4 (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .loop_en(loop_en),
        .audio_in_available(avail), .left_channel_audio_in(lch), .right_channel_audio_in(rch),
        .read_audio_in(rd4), .ram_address(addr4), .ram_data(data4), .ram_wren(wren4),
        .busy(busy4), .done(done4), .sample_count(sc4)
    );

    // Log every RAM write mid-cycle.
    always @(negedge clk) begin
        if (resetn && wren1) begin
            wa1.push_back(addr1);
            wd1.push_back(data1);
        end
        if (resetn && wren4) begin
            wa4.push_back(addr4);
            wd4.push_back(data4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        avail = 1'b0; lch = '0; rch = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        wa1.delete(); wd1.delete(); wa4.delete(); wd4.delete();
    endtask

    task automatic start_rec();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] l, input logic [31:0] r);
        avail = 1'b1; lch = l; rch = r;
        tick();
        avail = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        avail = 1'b0; lch = '0; rch = '0;
        #3;
        checks++; if (wren1 !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", wren1); end
        checks++; if (addr1 !== 7'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", data1); end
        checks++; if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy1, done1}); end
        checks++; if (sc1 !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", sc1); end
        checks++; if (rd1 !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", rd1); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        apply_reset();
        start_rec();
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy1); end
        for (int i = 0; i < 100; i++) begin
            feed(32'h0000_0100, 32'h0000_0100);
            tick(); tick(); tick();
        end
        checks++;
        if (wa1.size() !== 100) begin errors++; $display("FAIL basic_nwrites: got %0d expected 100", wa1.size()); end
        for (int i = 0; i < 100 && i < wa1.size(); i++) begin
            checks++;
            if (wa1[i] !== 7'(i) || wd1[i] !== 32'h0000_0100) begin
                errors++;
                $display("FAIL basic_write[%0d]: got addr %0d data %h expected addr %0d data 00000100", i, wa1[i], wd1[i], i);
            end
        end
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy1); end
        checks++; if (sc1 !== 8'd100) begin errors++; $display("FAIL basic_count: got %0d expected 100", sc1); end
        checks++; if (addr1 !== 7'd99) begin errors++; $display("FAIL basic_addr_hold: got %0d expected 99", addr1); end
        avail = 1'b1; lch = 32'h1234; rch = 32'h1234;
        #1;
        checks++; if (rd1 !== 1'b1) begin errors++; $display("FAIL done_drain: got %b expected 1", rd1); end
        tick(); tick(); tick();
        avail = 1'b0;
        tick();
        checks++; if (wa1.size() !== 100) begin errors++; $display("FAIL done_no_write: got %0d writes expected 100", wa1.size()); end
    endtask

    task automatic test_mono();
        apply_reset();
        start_rec();
        feed(32'hFFFF_FFFE, 32'h0000_0001);
        checks++; if (wren1 !== 1'b1) begin errors++; $display("FAIL mono_latency: got wren %b expected 1", wren1); end
        checks++; if (data1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mono_neg: got %h expected ffffffff", data1); end
        checks++; if (addr1 !== 7'd0) begin errors++; $display("FAIL mono_addr0: got %0d expected 0", addr1); end
        tick();
        checks++; if (wren1 !== 1'b0) begin errors++; $display("FAIL mono_one_cycle: got wren %b expected 0", wren1); end
        feed(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        checks++; if (data1 !== 32'h7FFF_FFFE || addr1 !== 7'd1) begin errors++; $display("FAIL mono_max: got %h@%0d expected 7ffffffe@1", data1, addr1); end
        tick();
        feed(32'h8000_0000, 32'h8000_0000);
        checks++; if (data1 !== 32'h8000_0000) begin errors++; $display("FAIL mono_min: got %h expected 80000000", data1); end
        tick();
        feed(32'h0000_0003, 32'h0000_0005);
        checks++; if (data1 !== 32'h0000_0003) begin errors++; $display("FAIL mono_odd: got %h expected 00000003", data1); end
        tick();
        feed(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (data1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mono_m1: got %h expected fffffffe", data1); end
        tick();
        checks++; if (sc1 !== 8'd5) begin errors++; $display("FAIL mono_count: got %0d expected 5", sc1); end
    endtask

    task automatic test_decim();
        int rdlow;
        int rdlow_w;
        rdlow = 0;
        rdlow_w = 0;
        apply_reset();
        start_rec();
        for (int c = 0; c < 25; c++) begin
            avail = 1'b1;
            lch = 32'(2 * (c + 1));
            rch = 32'(2 * (c + 1));
            #1;
            if (!rd4) rdlow++;
            if (!rd4 && wren4) rdlow_w++;
            tick();
        end
        avail = 1'b0;
        tick();
        checks++; if (wa4.size() !== 5) begin errors++; $display("FAIL decim_nwrites: got %0d expected 5", wa4.size()); end
        for (int j = 0; j < 5 && j < wa4.size(); j++) begin
            checks++;
            if (wa4[j] !== 7'(j) || wd4[j] !== 32'(2 * (5 * j + 4))) begin
                errors++;
                $display("FAIL decim_write[%0d]: got %h@%0d expected %h@%0d", j, wd4[j], wa4[j], 32'(2 * (5 * j + 4)), j);
            end
        end
        checks++; if (rdlow !== 5) begin errors++; $display("FAIL decim_read_low: got %0d cycles expected 5", rdlow); end
        checks++; if (rdlow_w !== 5) begin errors++; $display("FAIL decim_read_low_in_write: got %0d expected 5", rdlow_w); end
        checks++; if (sc4 !== 8'd5) begin errors++; $display("FAIL decim_count: got %0d expected 5", sc4); end
    endtask

    task automatic test_loop();
        apply_reset();
        loop_en = 1'b1;
        start_rec();
        for (int i = 0; i < 105; i++) begin
            feed(32'(2 * i), 32'(2 * i));
            tick();
        end
        checks++; if (wa1.size() !== 105) begin errors++; $display("FAIL loop_nwrites: got %0d expected 105", wa1.size()); end
        for (int i = 0; i < 105 && i < wa1.size(); i++) begin
            checks++;
            if (wa1[i] !== 7'(i < 100 ? i : i - 100) || wd1[i] !== 32'(2 * i)) begin
                errors++;
                $display("FAIL loop_write[%0d]: got %h@%0d expected %h@%0d", i, wd1[i], wa1[i], 32'(2 * i), (i < 100 ? i : i - 100));
            end
        end
        checks++; if (sc1 !== 8'd100) begin errors++; $display("FAIL loop_count_sat: got %0d expected 100", sc1); end
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL loop_status: got done %b busy %b expected 0 1", done1, busy1); end
        loop_en = 1'b0;
    endtask

    task automatic test_stop();
        apply_reset();
        start_rec();
        for (int i = 0; i < 9; i++) begin
            feed(32'(4 * i), 32'(4 * i));
            tick();
        end
        avail = 1'b1; lch = 32'h40; rch = 32'h40; stop = 1'b1;
        tick();
        avail = 1'b0;
        checks++; if (wren1 !== 1'b1 || addr1 !== 7'd9) begin errors++; $display("FAIL stop_keep_write: got wren %b addr %0d expected 1 9", wren1, addr1); end
        tick();
        stop = 1'b0;
        checks++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL stop_done: got done %b busy %b expected 1 0", done1, busy1); end
        checks++; if (sc1 !== 8'd10) begin errors++; $display("FAIL stop_count: got %0d expected 10", sc1); end
        checks++; if (wa1.size() !== 10) begin errors++; $display("FAIL stop_nwrites: got %0d expected 10", wa1.size()); end
        start_rec();
        checks++; if (busy1 !== 1'b1 || sc1 !== 8'd0) begin errors++; $display("FAIL restart_state: got busy %b count %0d expected 1 0", busy1, sc1); end
        feed(32'h8, 32'h8);
        tick();
        checks++;
        if (wa1.size() !== 11 || wa1[wa1.size()-1] !== 7'd0) begin
            errors++;
            $display("FAIL restart_addr: got %0d writes, last addr %0d expected 11, 0", wa1.size(), wa1[wa1.size()-1]);
        end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        start_rec();
        feed(32'h100, 32'h100);
        checks++; if (wren1 !== 1'b1) begin errors++; $display("FAIL midrst_pre: got wren %b expected 1", wren1); end
        #1 resetn = 1'b0;
        #1;
        checks++; if (wren1 !== 1'b0) begin errors++; $display("FAIL midrst_async_wren: got %b expected 0", wren1); end
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if ({wren1, busy1, done1} !== 3'b000 || addr1 !== 7'd0 || data1 !== 32'd0 || sc1 !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got wren %b busy %b done %b addr %0d data %h count %0d expected all 0",
                     wren1, busy1, done1, addr1, data1, sc1);
        end
        avail = 1'b1; lch = 32'h55; rch = 32'h55;
        #1;
        checks++; if (rd1 !== 1'b1) begin errors++; $display("FAIL idle_drain: got %b expected 1", rd1); end
        tick(); tick();
        avail = 1'b0;
        checks++; if (wren1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL idle_stays: got wren %b busy %b expected 0 0", wren1, busy1); end
        tick();
        checks++; if (wa1.size() !== 0) begin errors++; $display("FAIL midrst_lost: got %0d writes expected 0", wa1.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mono();
        test_decim();
        test_loop();
        test_stop();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_recorder.md
Name: audio_recorder

Overview:
- Capture-side counterpart of the RAM-playback path.
- Pulls samples from the Audio_Controller input FIFO via its read handshake, mixes left/right to mono, and decimates.
- Writes the result sequentially into the same single-port ram (7-bit address, 32-bit word) that the playback logic reads.
- Sits between Audio_Controller outputs and the ram write port, in the CLOCK_50 domain.

Parameters:
- ADDR_W, 7, RAM address width.
- LAST_ADDR, 99, final RAM address written; recording covers 0..LAST_ADDR.
- DECIM, 1, keep one of every DECIM accepted samples; legal range 1..255.

Ports:
- CLOCK_50  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  level-sampled each cycle; begins recording at address 0 from IDLE or DONE.
- stop  input  1  ends recording early.
- loop_en  input  1  when 1, wrap to address 0 after LAST_ADDR instead of finishing.
- audio_in_available  input  1  Audio_Controller: input FIFO non-empty.
- left_channel_audio_in  input  32  signed left sample, valid while audio_in_available.
- right_channel_audio_in  input  32  signed right sample.
- read_audio_in  output  1  pop strobe to Audio_Controller.
- ram_address  output  ADDR_W  RAM address.
- ram_data  output  32  RAM write data.
- ram_wren  output  1  RAM write enable.
- busy  output  1  high in RECORD and WRITE.
- done  output  1  high in DONE.
- sample_count  output  ADDR_W+1  words written since the last start; saturates at LAST_ADDR+1.

Behaviour:
- Reset (async, resetn=0): state IDLE; read_audio_in=0, ram_wren=0, ram_address=0, ram_data=0, busy=0, done=0, sample_count=0, decimation counter=0. Reset mid-write aborts the write: no further wren, and the pending word is lost.
- States: IDLE, RECORD, WRITE, DONE.
- Accept: a sample is accepted in any cycle where read_audio_in=1 and audio_in_available=1. The data inputs are sampled in that same cycle.
- read_audio_in is combinational:
  - IDLE, DONE, RECORD: equals audio_in_available. Idle and done drain the FIFO so no stale audio is recorded.
  - WRITE: 0.
- Mono mix: mono = (L >>> 1) + (R >>> 1), 32-bit signed, arithmetic shift, no saturation (the shifted sum cannot overflow).
- Decimation: a counter increments on each accept in RECORD. When it equals DECIM-1, the accept is a keep: ram_data<=mono, counter<=0, next state WRITE. With DECIM=1, every accept is kept.
- IDLE:
  - start=1 -> RECORD; wr_addr=0, sample_count=0, counter=0.
  - Otherwise stay.
- RECORD:
  - Keep -> WRITE.
  - stop=1 with no keep in the same cycle -> DONE.
  - stop and keep in the same cycle: the keep wins; go to WRITE and finish via the stop check there.
  - start ignored.
- WRITE (exactly 1 cycle): ram_wren=1, ram_address=wr_addr, ram_data held; sample_count+1 (saturating). Then:
  - wr_addr==LAST_ADDR and loop_en=0 -> DONE, wr_addr stays LAST_ADDR.
  - wr_addr==LAST_ADDR and loop_en=1 -> wr_addr=0, RECORD.
  - stop=1 (any address) -> DONE.
  - Else wr_addr+1, RECORD.
- DONE: done=1. start=1 -> RECORD, restarting at address 0 with counts cleared.
- Outside WRITE: ram_wren=0 and ram_address=wr_addr, so a write occurs only in WRITE.
- Keep-to-RAM latency: keep accept cycle N -> ram_wren=1 in cycle N+1. Minimum spacing between writes is 2 cycles.
- busy=1 in RECORD/WRITE; done=1 in DONE only. Both are registered from the state.

Test Plan:
- Reset, start=1 pulse, feed 100 samples with L=R=0x00000100, available every 4 cycles -> 100 wren pulses at addresses 0..99, each data 0x00000100; then done=1, sample_count=100, no wren thereafter.
- L=0xFFFFFFFE (-2), R=0x00000001 -> ram_data=0xFFFFFFFF (-1+0). L=R=0x7FFFFFFF -> 0x7FFFFFFE.
- DECIM=4, 20 accepts after start -> 5 writes at addresses 0..4 holding samples #4,#8,#12,#16,#20; read_audio_in low only in the 5 WRITE cycles.
- loop_en=1, 105 kept samples -> addresses 0..99 then 0..4; sample_count=100 (saturated); done stays 0.
- stop=1 asserted in the same cycle as the 10th keep -> that write occurs at address 9, then DONE, sample_count=10. start=1 in DONE -> next write at address 0.
- resetn=0 asserted during a WRITE cycle -> ram_wren drops immediately (async); after release all outputs are 0 and state is IDLE. In IDLE with available=1, read_audio_in=1 and no wren.
